// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, drives the synchronous ROM address port and
// hands fetched words to the decoder through an output register backed by a one-entry skid buffer.
module instr_fetch #(
   parameter int AW = 6,
   parameter int IW = 8
) (
   input  logic          clk,
   input  logic          reset,
   output logic          imem_en,
   output logic [AW-1:0] imem_addr,
   input  logic [IW-1:0] imem_data,
   output logic [IW-1:0] instr,
   output logic [AW-1:0] instr_addr,
   output logic          instr_valid,
   input  logic          instr_ready,
   input  logic          branch_en,
   input  logic [AW-1:0] branch_target
);

   localparam logic [AW-1:0] PC_STEP = AW'(1);

   logic [AW-1:0] pc_r;
   logic          fly_r;
   logic [AW-1:0] fly_addr_r;
   logic          sk_valid_r;
   logic [IW-1:0] sk_data_r;
   logic [AW-1:0] sk_addr_r;
   logic          out_free_s;
   logic          issue_s;

   // Issue only when the returning word is guaranteed a slot: skid empty and OUT free.
   always_comb begin
      out_free_s = !instr_valid || instr_ready;
      if (reset || branch_en) begin
         issue_s = 1'b0;
      end else begin
         issue_s = !sk_valid_r && out_free_s;
      end
   end

   assign imem_en   = issue_s;
   assign imem_addr = pc_r;

   // PC, in-flight tracking, output register and skid buffer.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_r        <= {AW{1'b0}};
         fly_r       <= 1'b0;
         fly_addr_r  <= {AW{1'b0}};
         sk_valid_r  <= 1'b0;
         sk_data_r   <= {IW{1'b0}};
         sk_addr_r   <= {AW{1'b0}};
         instr       <= {IW{1'b0}};
         instr_addr  <= {AW{1'b0}};
         instr_valid <= 1'b0;
      end else if (branch_en) begin
         // The word already requested from the ROM is dropped by clearing fly_r.
         pc_r        <= branch_target;
         fly_r       <= 1'b0;
         sk_valid_r  <= 1'b0;
         instr_valid <= 1'b0;
      end else begin
         if (issue_s) begin
            pc_r       <= pc_r + PC_STEP;
            fly_r      <= 1'b1;
            fly_addr_r <= pc_r;
         end else begin
            fly_r <= 1'b0;
         end

         if (out_free_s) begin
            if (sk_valid_r) begin
               // Skid holds the older word, so it moves first.
               instr       <= sk_data_r;
               instr_addr  <= sk_addr_r;
               instr_valid <= 1'b1;
               if (fly_r) begin
                  sk_data_r <= imem_data;
                  sk_addr_r <= fly_addr_r;
               end else begin
                  sk_valid_r <= 1'b0;
               end
            end else if (fly_r) begin
               instr       <= imem_data;
               instr_addr  <= fly_addr_r;
               instr_valid <= 1'b1;
            end else begin
               instr_valid <= 1'b0;
            end
         end else if (fly_r) begin
            sk_data_r  <= imem_data;
            sk_addr_r  <= fly_addr_r;
            sk_valid_r <= 1'b1;
         end else begin
            sk_valid_r <= sk_valid_r;
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: behavioural ROM with ROM[i] = i ^ 8'hA5,
// cycle-by-cycle checks of reset, streaming, wrap, stall, branch and mid-stream reset.
module tb_instr_fetch;
   localparam int AW = 6;
   localparam int IW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          imem_en;
   logic [AW-1:0] imem_addr;
   logic [IW-1:0] imem_data = 8'h00;
   logic [IW-1:0] instr;
   logic [AW-1:0] instr_addr;
   logic          instr_valid;
   logic          instr_ready;
   logic          branch_en;
   logic [AW-1:0] branch_target;

   int total = 0;
   int bad   = 0;
   int exp_a;

   instr_fetch #(.AW(AW), .IW(IW)) dut (
      .clk(clk), .reset(reset), .imem_en(imem_en), .imem_addr(imem_addr),
      .imem_data(imem_data), .instr(instr), .instr_addr(instr_addr),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .branch_en(branch_en), .branch_target(branch_target)
   );

   always #5 clk = ~clk;

   // Synchronous ROM: data appears the cycle after the read strobe.
   always @(posedge clk) begin
      if (imem_en) imem_data <= 8'(imem_addr) ^ 8'hA5;
   end

   function automatic logic [31:0] rom(input int a);
      logic [7:0] w;
      w = 8'(a) ^ 8'hA5;
      return {24'h0, w};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic see(input string tag, input int a);
      chk({tag, "_v"}, 32'(instr_valid), 32'd1);
      chk({tag, "_a"}, 32'(instr_addr), 32'(a));
      chk({tag, "_d"}, 32'(instr), rom(a));
   endtask

   initial begin
      reset = 1'b1; instr_ready = 1'b0; branch_en = 1'b0; branch_target = 6'd0;
      repeat (3) step();
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", 32'(instr), 32'd0);
      chk("rst_iaddr", 32'(instr_addr), 32'd0);
      #1 chk("rst_en", 32'(imem_en), 32'd0);

      // Cycle 0: first cycle with reset low
      reset = 1'b0; instr_ready = 1'b1;
      #1;
      chk("c0_en", 32'(imem_en), 32'd1);
      chk("c0_addr", 32'(imem_addr), 32'd0);
      chk("c0_valid", 32'(instr_valid), 32'd0);
      step();
      chk("c1_valid", 32'(instr_valid), 32'd0);
      #1;
      chk("c1_en", 32'(imem_en), 32'd1);
      chk("c1_addr", 32'(imem_addr), 32'd1);
      step();
      see("c2", 0);

      // Free run across the 63 -> 0 wrap up to OUT = 10
      exp_a = 1;
      for (int i = 0; i < 74; i++) begin
         step();
         see("run", exp_a);
         exp_a = (exp_a + 1) % 64;
      end

      // Stall for 5 cycles with 10 in OUT
      instr_ready = 1'b0;
      #1 chk("stall_en0", 32'(imem_en), 32'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         see("stall_hold", 10);
         #1 chk("stall_en", 32'(imem_en), 32'd0);
      end
      step();
      instr_ready = 1'b1;
      see("drain10", 10);
      #1 chk("drain_en0", 32'(imem_en), 32'd0);
      step();
      see("drain11", 11);
      #1;
      chk("resume_en", 32'(imem_en), 32'd1);
      chk("resume_addr", 32'(imem_addr), 32'd12);
      step();
      chk("bubble_v", 32'(instr_valid), 32'd0);
      step();
      see("post12", 12);
      step();
      see("post13", 13);

      // Run on until OUT = 4 (5 in flight, 6 about to issue)
      exp_a = 14;
      for (int i = 0; i < 55; i++) begin
         step();
         see("run2", exp_a);
         exp_a = (exp_a + 1) % 64;
      end

      // Branch to 40
      branch_en = 1'b1; branch_target = 6'd40;
      #1 chk("br_en0", 32'(imem_en), 32'd0);
      step();
      branch_en = 1'b0;
      chk("br1_v", 32'(instr_valid), 32'd0);
      #1;
      chk("br1_en", 32'(imem_en), 32'd1);
      chk("br1_addr", 32'(imem_addr), 32'd40);
      step();
      chk("br2_v", 32'(instr_valid), 32'd0);
      #1 chk("br2_addr", 32'(imem_addr), 32'd41);
      step();
      see("br3", 40);
      step();
      see("br4", 41);
      step();
      see("br5", 42);

      // Stall with the skid full, then branch to 20
      instr_ready = 1'b0;
      step();
      see("sk_hold", 42);
      step();
      see("sk_hold2", 42);
      branch_en = 1'b1; branch_target = 6'd20;
      #1 chk("sbr_en0", 32'(imem_en), 32'd0);
      step();
      branch_en = 1'b0; instr_ready = 1'b1;
      chk("sbr1_v", 32'(instr_valid), 32'd0);
      #1;
      chk("sbr1_en", 32'(imem_en), 32'd1);
      chk("sbr1_addr", 32'(imem_addr), 32'd20);
      step();
      chk("sbr2_v", 32'(instr_valid), 32'd0);
      step();
      see("sbr3", 20);
      step();
      see("sbr4", 21);

      // Fill the skid, then a one-cycle reset coinciding with a branch
      instr_ready = 1'b0;
      step();
      see("rsk_hold", 21);
      reset = 1'b1; branch_en = 1'b1; branch_target = 6'd33;
      #1 chk("mrst_en", 32'(imem_en), 32'd0);
      step();
      reset = 1'b0; branch_en = 1'b0; instr_ready = 1'b1;
      chk("mrst_v", 32'(instr_valid), 32'd0);
      chk("mrst_iaddr", 32'(instr_addr), 32'd0);
      chk("mrst_instr", 32'(instr), 32'd0);
      #1;
      chk("mrst_en1", 32'(imem_en), 32'd1);
      chk("mrst_addr", 32'(imem_addr), 32'd0);
      step();
      chk("mrst1_v", 32'(instr_valid), 32'd0);
      #1 chk("mrst1_addr", 32'(imem_addr), 32'd1);
      step();
      see("mrst2", 0);
      step();
      see("mrst3", 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
